rf_write_ctrl: RTL and testbench

Write-side controller for the integer register file. It owns the register file's single write port (`we0`, `wr_addr0`, `wr_din0`) and performs three jobs:
- a sequential clear sweep after reset, replacing the asynchronous combinational clear;
- a registered writeback stage that formats RV32I load data (LB/LH/LW/LBU/LHU);
- discarding of writes to x0, with an error report for misaligned or illegal loads.

It sits between the writeback source and the register file.

---
 rtl/rf_write_ctrl.sv | 158 +++++++++++++++
 tb/tb_rf_write_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_ctrl.sv
// Write-port controller for the integer register file: post-reset clear sweep,
// registered RV32I load formatting, x0 discard. Optional forwarding via `RF_WR_FWD_EN.
//
// state | meaning
// RESET | held in reset, outputs at reset values
// SWEEP | writing INIT_VAL to registers 1..DEPTH-1, one per cycle
// RUN   | accepting writeback transactions
module rf_write_ctrl #(
    parameter int                WIDTH    = 32,
    parameter int                DEPTH    = 32,
    parameter logic [WIDTH-1:0]  INIT_VAL = '0,
    localparam int               AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rd,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    output logic             we0,
    output logic [AW-1:0]    wr_addr0,
    output logic [WIDTH-1:0] wr_din0,
    output logic             busy,
    output logic             load_err
`ifdef RF_WR_FWD_EN
    ,
    input  logic [AW-1:0]    fwd_rs1,
    input  logic [AW-1:0]    fwd_rs2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [WIDTH-1:0] fwd_data1,
    output logic [WIDTH-1:0] fwd_data2
`endif
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SWEEP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_FIRST = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic             err_q, err_d;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] fmt_data;
    logic             fmt_bad;

    assign ld_byte = in_data[{in_addr_lo, 3'b000} +: 8];
    assign ld_half = in_data[{in_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        fmt_data = in_data;
        fmt_bad  = 1'b0;
        if (in_is_load) begin
            case (in_funct3)
                3'd0: fmt_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
                3'd4: fmt_data = {{(WIDTH-8){1'b0}}, ld_byte};
                3'd1: begin
                    fmt_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
                    fmt_bad  = in_addr_lo[0];
                end
                3'd5: begin
                    fmt_data = {{(WIDTH-16){1'b0}}, ld_half};
                    fmt_bad  = in_addr_lo[0];
                end
                3'd2: fmt_bad = (in_addr_lo != 2'd0);
                default: fmt_bad = 1'b1;
            endcase
        end
    end

    assign in_ready = (state_q == ST_RUN) && !clear_req;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        err_d   = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_SWEEP;
                we_d    = 1'b1;
                addr_d  = ADDR_FIRST;
                din_d   = INIT_VAL;
            end
            ST_SWEEP: begin
                // addr_q doubles as the sweep counter
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_FIRST;
                    din_d  = INIT_VAL;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_SWEEP;
                    we_d    = 1'b1;
                    addr_d  = ADDR_FIRST;
                    din_d   = INIT_VAL;
                end else if (in_valid) begin
                    if (fmt_bad) begin
                        err_d = 1'b1;
                    end else if (in_rd != '0) begin
                        we_d   = 1'b1;
                        addr_d = in_rd;
                        din_d  = fmt_data;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RESET;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    assign we0      = we_q;
    assign wr_addr0 = addr_q;
    assign wr_din0  = din_q;
    assign busy     = (state_q != ST_RUN);
    assign load_err = err_q;

`ifdef RF_WR_FWD_EN
    assign fwd_hit1  = we_q && !busy && (addr_q == fwd_rs1) && (fwd_rs1 != '0);
    assign fwd_hit2  = we_q && !busy && (addr_q == fwd_rs2) && (fwd_rs2 != '0);
    assign fwd_data1 = din_q;
    assign fwd_data2 = din_q;
`endif

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl: reset sweep, load formatting, errors/x0,
// back-to-back writes, clear and reset mid-sweep; forwarding checks when RF_WR_FWD_EN is set.
module tb_rf_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        we0;
    logic [4:0]  wr_addr0;
    logic [31:0] wr_din0;
    logic        busy;
    logic        load_err;
`ifdef RF_WR_FWD_EN
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_ctrl #(.WIDTH(32), .DEPTH(32), .INIT_VAL(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .we0        (we0),
        .wr_addr0   (wr_addr0),
        .wr_din0    (wr_din0),
        .busy       (busy),
        .load_err   (load_err)
`ifdef RF_WR_FWD_EN
        ,
        .fwd_rs1    (fwd_rs1),
        .fwd_rs2    (fwd_rs2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        we;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expects address first-1 presented (or reset just released); walks the rest of the sweep.
    task automatic run_sweep(input int first, input bit poke_clear);
        for (int k = first; k <= 31; k++) begin
            step();
            chk($sformatf("sweep_we%0d", k), {31'b0, we0}, 32'd1);
            chk($sformatf("sweep_addr%0d", k), {27'b0, wr_addr0}, k);
            chk("sweep_din", wr_din0, 32'h0);
            chk("sweep_busy", {31'b0, busy}, 32'd1);
            chk("sweep_rdy", {31'b0, in_ready}, 32'd0);
            if (poke_clear && k == 4)  clear_req = 1'b1;
            if (poke_clear && k == 10) clear_req = 1'b0;
        end
        step();
        chk("sweep_end_we", {31'b0, we0}, 32'd0);
        chk("sweep_end_busy", {31'b0, busy}, 32'd0);
        chk("sweep_end_rdy", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{5'd1,  32'h80F07F01, 1'b1, 3'd0, 2'd3, 1'b1, 32'hFFFFFF80, 1'b0};
        vecs[1]  = '{5'd2,  32'h80F07F01, 1'b1, 3'd4, 2'd3, 1'b1, 32'h00000080, 1'b0};
        vecs[2]  = '{5'd3,  32'h80F07F01, 1'b1, 3'd1, 2'd2, 1'b1, 32'hFFFF80F0, 1'b0};
        vecs[3]  = '{5'd4,  32'h80F07F01, 1'b1, 3'd5, 2'd0, 1'b1, 32'h00007F01, 1'b0};
        vecs[4]  = '{5'd10, 32'h80F07F01, 1'b1, 3'd2, 2'd0, 1'b1, 32'h80F07F01, 1'b0};
        vecs[5]  = '{5'd11, 32'h80F07F01, 1'b1, 3'd2, 2'd1, 1'b0, 32'h0,        1'b1};
        vecs[6]  = '{5'd12, 32'h80F07F01, 1'b1, 3'd3, 2'd0, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{5'd0,  32'h00001234, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0,        1'b0};
        vecs[8]  = '{5'd13, 32'h80F07F01, 1'b1, 3'd1, 2'd1, 1'b0, 32'h0,        1'b1};
        vecs[9]  = '{5'd0,  32'h80F07F01, 1'b1, 3'd5, 2'd3, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{5'd14, 32'h80F07F01, 1'b1, 3'd6, 2'd0, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{5'd5,  32'h00000055, 1'b0, 3'd7, 2'd1, 1'b1, 32'h00000055, 1'b0};
        vecs[12] = '{5'd6,  32'h00000066, 1'b0, 3'd3, 2'd0, 1'b1, 32'h00000066, 1'b0};
        vecs[13] = '{5'd7,  32'h00000077, 1'b0, 3'd0, 2'd0, 1'b1, 32'h00000077, 1'b0};
        vecs[14] = '{5'd8,  32'h00000088, 1'b0, 3'd2, 2'd2, 1'b1, 32'h00000088, 1'b0};

        rst = 1'b0; clear_req = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
        in_is_load = 1'b0; in_funct3 = '0; in_addr_lo = '0;
`ifdef RF_WR_FWD_EN
        fwd_rs1 = 5'd1; fwd_rs2 = 5'd1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", {31'b0, we0}, 32'd0);
        chk("rst_addr", {27'b0, wr_addr0}, 32'd0);
        chk("rst_din", wr_din0, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_err", {31'b0, load_err}, 32'd0);
        chk("rst_rdy", {31'b0, in_ready}, 32'd0);

        // clear_req held mid-sweep must not restart it
        rst = 1'b1;
        run_sweep(1, 1'b1);

        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_rd = vecs[i].rd; in_data = vecs[i].d;
            in_is_load = vecs[i].ld; in_funct3 = vecs[i].f3; in_addr_lo = vecs[i].lo;
            #1;
            chk($sformatf("v%0d_rdy", i), {31'b0, in_ready}, 32'd1);
            step();
            chk($sformatf("v%0d_we", i), {31'b0, we0}, {31'b0, vecs[i].we});
            chk($sformatf("v%0d_err", i), {31'b0, load_err}, {31'b0, vecs[i].err});
            if (vecs[i].we) begin
                chk($sformatf("v%0d_addr", i), {27'b0, wr_addr0}, {27'b0, vecs[i].rd});
                chk($sformatf("v%0d_din", i), wr_din0, vecs[i].exp);
            end
        end
        in_valid = 1'b0;
        step();
        chk("idle_we", {31'b0, we0}, 32'd0);
        chk("idle_err", {31'b0, load_err}, 32'd0);
        chk("idle_addr_hold", {27'b0, wr_addr0}, 32'd8);
        chk("idle_din_hold", wr_din0, 32'h88);

`ifdef RF_WR_FWD_EN
        in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hDEADBEEF; in_is_load = 1'b0;
        step();
        in_valid = 1'b0; fwd_rs1 = 5'd7; fwd_rs2 = 5'd0;
        #1;
        chk("fwd_hit1", {31'b0, fwd_hit1}, 32'd1);
        chk("fwd_data1", fwd_data1, 32'hDEADBEEF);
        chk("fwd_hit2", {31'b0, fwd_hit2}, 32'd0);
        fwd_rs1 = 5'd1; fwd_rs2 = 5'd1;
        step();
`endif

        in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h00000099; in_is_load = 1'b0;
        step();
        clear_req = 1'b1; in_rd = 5'd20; in_data = 32'h0000BAD0;
        #1;
        chk("clr_rdy", {31'b0, in_ready}, 32'd0);
        chk("clr_x9_we", {31'b0, we0}, 32'd1);
        chk("clr_x9_addr", {27'b0, wr_addr0}, 32'd9);
        chk("clr_x9_din", wr_din0, 32'h99);
        step();
        clear_req = 1'b0; in_valid = 1'b0;
        chk("clr_sw_we", {31'b0, we0}, 32'd1);
        chk("clr_sw_addr", {27'b0, wr_addr0}, 32'd1);
        chk("clr_sw_busy", {31'b0, busy}, 32'd1);
`ifdef RF_WR_FWD_EN
        chk("fwd_sweep_hit1", {31'b0, fwd_hit1}, 32'd0);
        chk("fwd_sweep_hit2", {31'b0, fwd_hit2}, 32'd0);
`endif
        run_sweep(2, 1'b0);

        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (3) step();
        chk("mid_addr", {27'b0, wr_addr0}, 32'd4);
        rst = 1'b0;
        step();
        chk("mid_rst_we", {31'b0, we0}, 32'd0);
        chk("mid_rst_addr", {27'b0, wr_addr0}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd1);
        chk("mid_rst_rdy", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        run_sweep(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
